// File: rtl/frame_stream_pkg.sv
// ---------------------------------------------------------------------------
// frame_stream_pkg
// Shared definitions for the frame_stream_src raster pixel source:
//   - state_t   : streaming FSM states
//   - addr_w()  : ceil(log2(n)) with a floor of 1 bit, used for all counter
//                 and address widths
//   - max2()    : integer maximum, used to size the blanking counter
//   - SKID_DEPTH: entries in the backpressure skid buffer
// ---------------------------------------------------------------------------
package frame_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VBLANK = 3'd1,
    ST_HBLANK = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  localparam int SKID_DEPTH = 2;

  function automatic int addr_w(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_stream_src_skid.sv
// ---------------------------------------------------------------------------
// stream_skid_buf
// Two-entry FIFO that parks pixels which arrive from memory while the
// consumer is stalling. Compiled only when FRAME_STREAM_BP_EN is defined.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_push/i_data: write one entry
//   i_pop        : drop the head entry
//   o_count      : number of entries held (0..2)
//   o_head       : oldest entry (meaningful when o_count != 0)
// ---------------------------------------------------------------------------
`ifdef FRAME_STREAM_BP_EN
module stream_skid_buf
  import frame_stream_pkg::*;
#(
  parameter int DW = 10
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_push,
  input  logic [DW-1:0]                      i_data,
  input  logic                               i_pop,
  output logic [addr_w(SKID_DEPTH+1)-1:0]    o_count,
  output logic [DW-1:0]                      o_head
);

  localparam int NW = addr_w(SKID_DEPTH + 1);

  logic [DW-1:0] r_mem [SKID_DEPTH];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [NW-1:0] r_count;

  // Storage, pointers and occupancy; push and pop may happen together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem[0] <= {DW{1'b0}};
      r_mem[1] <= {DW{1'b0}};
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= {NW{1'b0}};
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + NW'(1);
        2'b01:   r_count <= r_count - NW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule
`endif

// File: rtl/frame_stream_src.sv
// ---------------------------------------------------------------------------
// frame_stream_src
// Raster pixel source: on i_start reads one WIDTH x HEIGHT frame from a
// synchronous-read memory and streams it row-major with vertical and
// horizontal blanking and line/frame markers.
// Optional feature macro: FRAME_STREAM_BP_EN (consumer backpressure via
// i_rdy with a 2-entry skid buffer). Without it i_rdy is ignored.
// Ports:
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_start            : start pulse, honoured only when idle
//   o_mem_rd/o_mem_addr: memory read strobe and pixel index
//   i_mem_rdata        : read data, valid one cycle after o_mem_rd
//   o_vld/o_dout       : pixel stream (channel 0 in the LSBs)
//   o_line_last        : last pixel of a line
//   o_frame_last       : last pixel of the frame
//   i_rdy              : consumer ready (backpressure builds only)
//   o_busy             : high whenever not idle
//   o_frame_done       : one-cycle pulse after the final pixel transfer
// ---------------------------------------------------------------------------
module frame_stream_src
  import frame_stream_pkg::*;
#(
  parameter int WIDTH       = 128,
  parameter int HEIGHT      = 128,
  parameter int WI          = 8,
  parameter int CH          = 1,
  parameter int VSYNC_DELAY = 200,
  parameter int HSYNC_DELAY = 160
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_start,
  output logic                                  o_mem_rd,
  output logic [addr_w(WIDTH*HEIGHT)-1:0]       o_mem_addr,
  input  logic [CH*WI-1:0]                      i_mem_rdata,
  output logic                                  o_vld,
  output logic [CH*WI-1:0]                      o_dout,
  output logic                                  o_line_last,
  output logic                                  o_frame_last,
  input  logic                                  i_rdy,
  output logic                                  o_busy,
  output logic                                  o_frame_done
);

  localparam int AW = addr_w(WIDTH * HEIGHT);
  localparam int DW = CH * WI;
  localparam int BW = addr_w(max2(VSYNC_DELAY, HSYNC_DELAY) + 1);
  localparam int CW = addr_w(WIDTH);
  localparam int RW = addr_w(HEIGHT);
  localparam logic [BW-1:0] V_END = BW'(VSYNC_DELAY - 1);
  localparam logic [BW-1:0] H_END = BW'(HSYNC_DELAY - 1);
  localparam logic [CW-1:0] C_END = CW'(WIDTH - 1);
  localparam logic [RW-1:0] R_END = RW'(HEIGHT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [BW-1:0] r_blank_cnt;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [AW-1:0] r_mem_addr;
  logic          r_rd_d;      // read data arrives this cycle
  logic          r_ll_d;      // ... and it is the last pixel of a line
  logic          r_fl_d;      // ... and it is the last pixel of the frame
  logic          r_busy;
  logic          r_frame_done;

  logic          w_rd;
  logic          w_can_issue;
  logic          w_col_last;
  logic          w_row_last;
  logic [DW+1:0] w_out;       // {frame_last, line_last, pixel}
  logic          w_out_vld;
  logic          w_xfer;
  logic          w_out_ll;
  logic          w_out_fl;

`ifdef FRAME_STREAM_BP_EN
  logic [1:0]    w_buf_cnt;
  logic [DW+1:0] w_buf_head;
  logic          w_buf_empty;
  logic          w_push;
  logic          w_pop;
  logic          r_line_wait;  // last column issued, waiting for its acceptance

  // When the buffer is empty the arriving pixel bypasses it; it is only
  // parked if the consumer does not take it in the same cycle.
  assign w_buf_empty = (w_buf_cnt == 2'd0);
  assign w_push      = r_rd_d & ~(w_buf_empty & i_rdy);
  assign w_pop       = ~w_buf_empty & i_rdy;

  stream_skid_buf #(
    .DW (DW + 2)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  ({r_fl_d, r_ll_d, i_mem_rdata}),
    .i_pop   (w_pop),
    .o_count (w_buf_cnt),
    .o_head  (w_buf_head)
  );

  assign w_out     = w_buf_empty ? {r_fl_d, r_ll_d, i_mem_rdata} : w_buf_head;
  assign w_out_vld = ~w_buf_empty | r_rd_d;
  assign w_xfer    = w_out_vld & i_rdy;
  // Issue only if held + in-flight pixels leave a slot for this read even
  // if the consumer stalls from now on.
  assign w_can_issue = ((w_buf_cnt + {1'b0, r_rd_d}) <= 2'd1) & ~r_line_wait;

  // Hold ACTIVE after the line's last read until that pixel is accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_line_wait <= 1'b0;
    end else if ((r_state == ST_ACTIVE) && (w_state_nxt == ST_HBLANK)) begin
      r_line_wait <= 1'b0;
    end else if (w_rd && w_col_last && !w_row_last) begin
      r_line_wait <= 1'b1;
    end else begin
      r_line_wait <= r_line_wait;
    end
  end
`else
  logic w_unused_rdy;

  assign w_unused_rdy = i_rdy;
  assign w_out        = {r_fl_d, r_ll_d, i_mem_rdata};
  assign w_out_vld    = r_rd_d;
  assign w_xfer       = r_rd_d;
  assign w_can_issue  = 1'b1;
`endif

  assign w_col_last = (r_col == C_END);
  assign w_row_last = (r_row == R_END);
  assign w_out_ll   = w_out_vld & w_out[DW];
  assign w_out_fl   = w_out_vld & w_out[DW+1];

  // Read strobe: one pixel per ACTIVE cycle while buffer space allows.
  always_comb begin
    w_rd = 1'b0;
    if (r_state == ST_ACTIVE) begin
      w_rd = w_can_issue;
    end else begin
      w_rd = 1'b0;
    end
  end

  // Next-state logic of the streaming FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_nxt = ST_VBLANK;
        else         w_state_nxt = ST_IDLE;
      end
      ST_VBLANK: begin
        if (r_blank_cnt == V_END) w_state_nxt = ST_HBLANK;
        else                      w_state_nxt = ST_VBLANK;
      end
      ST_HBLANK: begin
        if (r_blank_cnt == H_END) w_state_nxt = ST_ACTIVE;
        else                      w_state_nxt = ST_HBLANK;
      end
      ST_ACTIVE: begin
`ifdef FRAME_STREAM_BP_EN
        if (w_rd && w_col_last && w_row_last) w_state_nxt = ST_DRAIN;
        else if (r_line_wait && w_xfer && w_out_ll) w_state_nxt = ST_HBLANK;
        else w_state_nxt = ST_ACTIVE;
`else
        if (w_rd && w_col_last) w_state_nxt = w_row_last ? ST_DRAIN : ST_HBLANK;
        else                    w_state_nxt = ST_ACTIVE;
`endif
      end
      ST_DRAIN: begin
        if (w_xfer && w_out_fl) w_state_nxt = ST_IDLE;
        else                    w_state_nxt = ST_DRAIN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus the busy / frame_done flags derived from it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_frame_done <= (r_state == ST_DRAIN) && (w_state_nxt == ST_IDLE);
    end
  end

  // Blanking counter restarts on every state change.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_blank_cnt <= {BW{1'b0}};
    end else if (r_state != w_state_nxt) begin
      r_blank_cnt <= {BW{1'b0}};
    end else if ((r_state == ST_VBLANK) || (r_state == ST_HBLANK)) begin
      r_blank_cnt <= r_blank_cnt + BW'(1);
    end else begin
      r_blank_cnt <= r_blank_cnt;
    end
  end

  // Raster position and running address (row*WIDTH+col without a multiplier).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col      <= {CW{1'b0}};
      r_row      <= {RW{1'b0}};
      r_mem_addr <= {AW{1'b0}};
    end else if ((r_state == ST_IDLE) && i_start) begin
      r_col      <= {CW{1'b0}};
      r_row      <= {RW{1'b0}};
      r_mem_addr <= {AW{1'b0}};
    end else if (w_rd) begin
      r_mem_addr <= r_mem_addr + AW'(1);
      if (w_col_last) begin
        r_col <= {CW{1'b0}};
        r_row <= w_row_last ? {RW{1'b0}} : (r_row + RW'(1));
      end else begin
        r_col <= r_col + CW'(1);
        r_row <= r_row;
      end
    end else begin
      r_col      <= r_col;
      r_row      <= r_row;
      r_mem_addr <= r_mem_addr;
    end
  end

  // Markers travel one cycle behind the read, alongside the memory data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_d <= 1'b0;
      r_ll_d <= 1'b0;
      r_fl_d <= 1'b0;
    end else begin
      r_rd_d <= w_rd;
      r_ll_d <= w_rd & w_col_last;
      r_fl_d <= w_rd & w_col_last & w_row_last;
    end
  end

  assign o_mem_rd     = w_rd;
  assign o_mem_addr   = r_mem_addr;
  assign o_vld        = w_out_vld;
  assign o_dout       = w_out_vld ? w_out[DW-1:0] : {DW{1'b0}};
  assign o_line_last  = w_out_ll;
  assign o_frame_last = w_out_fl;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_frame_stream_src.sv
// ---------------------------------------------------------------------------
// tb_frame_stream_src
// Directed bench for frame_stream_src: 4x3 frame, VSYNC 5, HSYNC 3, three
// 8-bit channels, memory word for pixel i = {i+2, i+1, i}.
// ---------------------------------------------------------------------------
module tb_frame_stream_src;

  localparam int W  = 4;
  localparam int HT = 3;
  localparam int V  = 5;
  localparam int HS = 3;
  localparam int WI = 8;
  localparam int CH = 3;
  localparam int DW = CH * WI;
  localparam int AW = 4;
`ifdef FRAME_STREAM_BP_EN
  localparam int BPX = 1;  // ACTIVE waits one cycle for the line's last acceptance
`else
  localparam int BPX = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          rdy;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          vld;
  logic [DW-1:0] dout;
  logic          ll;
  logic          fl;
  logic          busy;
  logic          fdone;

  int n_err = 0;
  int n_chk = 0;

  frame_stream_src #(
    .WIDTH (W), .HEIGHT (HT), .WI (WI), .CH (CH),
    .VSYNC_DELAY (V), .HSYNC_DELAY (HS)
  ) dut (
    .i_clk (clk), .i_rst (rst), .i_start (start),
    .o_mem_rd (mem_rd), .o_mem_addr (mem_addr), .i_mem_rdata (mem_rdata),
    .o_vld (vld), .o_dout (dout), .o_line_last (ll), .o_frame_last (fl),
    .i_rdy (rdy), .o_busy (busy), .o_frame_done (fdone)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word(input int p);
    return {8'(p + 2), 8'(p + 1), 8'(p)};
  endfunction

  // Synchronous-read pixel memory model.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= word(int'(mem_addr));
  end

  // Cycle (counted from the cycle after start) at which pixel p is on dout.
  function automatic int pix_time(input int p);
    return V + (p / W) * (HS + W + BPX) + HS + (p % W) + 2;
  endfunction

  function automatic int pix_at(input int k);
    for (int p = 0; p < W * HT; p++) begin
      if (pix_time(p) == k) return p;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame with cycle-exact checks; start is re-pulsed in [plo,phi].
  task automatic run_frame(input int plo, input int phi);
    int last_k;
    int p;
    int q;
    last_k = pix_time(W * HT - 1);
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= last_k + 3; k++) begin
      @(negedge clk);
      start = (k >= plo) && (k <= phi);
      p = pix_at(k);
      q = pix_at(k + 1);
      chk("busy", busy, k <= last_k);
      chk("vld", vld, p >= 0);
      chk("frame_done", fdone, k == last_k + 1);
      chk("mem_rd", mem_rd, q >= 0);
      if (q >= 0) chk("mem_addr", mem_addr, q);
      if (p >= 0) begin
        chk("dout", dout, word(p));
        chk("line_last", ll, (p % W) == W - 1);
        chk("frame_last", fl, p == W * HT - 1);
        if (p == 5) chk("pix5", dout, 24'h070605);
      end
    end
    start = 1'b0;
  endtask

`ifdef FRAME_STREAM_BP_EN
  // Backpressure frame: mode 0 random rdy (~30%), mode 1 a 20-cycle stall.
  task automatic run_bp(input int mode);
    int nxt;
    int reads;
    int stall;
    bit used;
    bit done;
    bit held_v;
    logic [DW-1:0] held_d;
    nxt = 0; reads = 0; stall = 0; used = 1'b0; done = 1'b0;
    held_v = 1'b0; held_d = '0;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (mode == 1) begin
        if (!used && nxt == W + 1 && vld) begin
          stall = 20;
          used  = 1'b1;
        end
        rdy = (stall == 0);
        if (stall > 0) stall--;
      end else begin
        rdy = ($urandom_range(9, 0) < 3);
      end
      if (held_v) begin
        chk("bp_hold_vld", vld, 1);
        chk("bp_hold_dout", dout, held_d);
      end
      if (mem_rd) begin
        reads++;
        chk("bp_outstanding", (reads - nxt) <= 2, 1);
      end
      if (fdone) begin
        chk("bp_done_after_last", nxt, W * HT);
        done = 1'b1;
      end
      if (vld && rdy) begin
        chk("bp_dout", dout, word(nxt));
        chk("bp_line_last", ll, (nxt % W) == W - 1);
        chk("bp_frame_last", fl, nxt == W * HT - 1);
        nxt++;
      end
      held_v = vld && !rdy;
      held_d = dout;
    end
    chk("bp_finished", done, 1);
    rdy = 1'b1;
  endtask
`endif

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    rdy       = 1'b1;
    mem_rdata = 24'hA5A5A5;
    repeat (3) @(negedge clk);
    chk("rst_vld", vld, 0);
    chk("rst_dout", dout, 0);
    chk("rst_line_last", ll, 0);
    chk("rst_frame_last", fl, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", fdone, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Plain frame, then restarts mid-frame and around the drain.
    run_frame(0, -1);
    run_frame(15, 15);
    run_frame(pix_time(W * HT - 1) - 2, pix_time(W * HT - 1));

    // Reset while the second line is being read.
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= pix_time(W + 1) - 1; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_mem_rd", mem_rd, 1);
    chk("pre_rst_addr", mem_addr, W + 1);
    chk("pre_rst_vld", vld, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_vld", vld, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mem_rd", mem_rd, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_done", fdone, 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_vld", vld, 0);
    end
    run_frame(0, -1);

`ifdef FRAME_STREAM_BP_EN
    run_bp(0);
    run_bp(1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
